// File: rtl/pdp8_ttx_pkg.sv
// Shared constants, types and device-code mapping for the pdp8_ttx serial controller.
package pdp8_ttx_pkg;

    // CPU state encodings seen on the IO bus
    localparam logic [3:0] ST_DECODE = 4'h1;
    localparam logic [3:0] ST_EXEC   = 4'h2;
    localparam logic [3:0] ST_COMMIT = 4'h3;

    // Keyboard IOT operation bits
    localparam logic [2:0] OP_KCF = 3'd0;
    localparam logic [2:0] OP_KSF = 3'd1;
    localparam logic [2:0] OP_KCC = 3'd2;
    localparam logic [2:0] OP_KRS = 3'd4;
    localparam logic [2:0] OP_KIE = 3'd5;
    localparam logic [2:0] OP_KRB = 3'd6;

    // Printer IOT operation bits
    localparam logic [2:0] OP_SPF = 3'd0;
    localparam logic [2:0] OP_TSF = 3'd1;
    localparam logic [2:0] OP_TCF = 3'd2;
    localparam logic [2:0] OP_TPC = 3'd4;
    localparam logic [2:0] OP_SPI = 3'd5;
    localparam logic [2:0] OP_TLS = 3'd6;

    // Device codes: channel 0 keeps the classic console codes
    localparam logic [5:0] KBD_CODE0 = 6'o03;
    localparam logic [5:0] PRT_CODE0 = 6'o04;
    localparam logic [5:0] KBD_BASE  = 6'o40;
    localparam logic [5:0] PRT_BASE  = 6'o41;

    localparam logic TX_FLAG_RST = 1'b1;
    localparam logic IE_RST      = 1'b1;
    localparam logic OVR_RST     = 1'b0;
    localparam logic LINE_IDLE   = 1'b1;

    typedef struct packed {
        logic [5:0] kbd;
        logic [5:0] prt;
    } dev_codes_t;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic dev_codes_t chan_codes(input int unsigned ch);
        dev_codes_t c;
        if (ch == 0) begin
            c.kbd = KBD_CODE0;
            c.prt = PRT_CODE0;
        end else begin
            c.kbd = KBD_BASE + 6'(2 * (ch - 1));
            c.prt = PRT_BASE + 6'(2 * (ch - 1));
        end
        return c;
    endfunction

endpackage

// File: rtl/pdp8_ttx_chan.sv
// One keyboard/printer channel: 8N1 transmitter, receiver, flags, ie and receive store.
// Receive FIFO enabled by TT_RX_FIFO_EN; otherwise a single holding register.
module pdp8_ttx_chan
    import pdp8_ttx_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kbd_sel,
    input  logic        prt_sel,
    input  logic        rd_phase,
    input  logic        commit,
    input  logic [2:0]  op,
    input  logic        ac_ie,
    input  logic [7:0]  ac_byte,
    input  logic        rxd,
    output logic        txd,
    output logic        skip,
    output logic        data_avail,
    output logic [11:0] data_out,
    output logic        irq
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);

    logic kbd_cmt, prt_cmt, pop_req, do_pop, do_push, full, rx_flag;
    logic [7:0] head;
    logic tx_flag, tx_flag_nx, ie, ovr;

    assign kbd_cmt = commit && kbd_sel;
    assign prt_cmt = commit && prt_sel;
    assign pop_req = kbd_cmt && (op == OP_KCF || op == OP_KCC || op == OP_KRB);

    // ---------------- transmitter ----------------
    tx_state_t tx_st, tx_st_nx;
    logic [8:0] tx_sh, tx_sh_nx;
    logic [3:0] tx_bit, tx_bit_nx;
    logic [DW-1:0] tx_div, tx_div_nx;
    logic txd_nx, tx_start, tx_done;

    assign tx_start = prt_cmt && (op == OP_TPC || op == OP_TLS) && (tx_st == TX_IDLE);

    always_comb begin
        tx_st_nx  = tx_st;
        tx_sh_nx  = tx_sh;
        tx_bit_nx = tx_bit;
        tx_div_nx = tx_div;
        txd_nx    = txd;
        tx_done   = 1'b0;
        case (tx_st)
            TX_IDLE: begin
                if (tx_start) begin
                    // start bit goes out immediately; remaining bits wait in tx_sh
                    tx_st_nx  = TX_SEND;
                    tx_sh_nx  = {1'b1, ac_byte};
                    tx_bit_nx = '0;
                    tx_div_nx = '0;
                    txd_nx    = 1'b0;
                end
            end
            TX_SEND: begin
                if (tx_div == DIV_LAST) begin
                    tx_div_nx = '0;
                    if (tx_bit == 4'd9) begin
                        tx_st_nx = TX_IDLE;
                        tx_done  = 1'b1;
                    end else begin
                        txd_nx    = tx_sh[0];
                        tx_sh_nx  = {1'b1, tx_sh[8:1]};
                        tx_bit_nx = tx_bit + 4'd1;
                    end
                end else begin
                    tx_div_nx = tx_div + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_flag_nx = tx_flag;
        if (prt_cmt) begin
            case (op)
                OP_SPF: tx_flag_nx = 1'b1;
                OP_TCF: tx_flag_nx = 1'b0;
                OP_TLS: if (tx_st == TX_IDLE) tx_flag_nx = 1'b0;
                default: ;
            endcase
        end
        if (tx_done) tx_flag_nx = 1'b1;
    end

    // ---------------- receiver ----------------
    rx_state_t rx_st, rx_st_nx;
    logic rx_m, rx_s, rx_p;
    logic [7:0] rx_sh, rx_sh_nx;
    logic [2:0] rx_bit, rx_bit_nx;
    logic [DW-1:0] rx_div, rx_div_nx;
    logic rx_push;

    always_comb begin
        rx_st_nx  = rx_st;
        rx_sh_nx  = rx_sh;
        rx_bit_nx = rx_bit;
        rx_div_nx = rx_div;
        rx_push   = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                if (rx_p && !rx_s) begin
                    rx_st_nx  = RX_START;
                    rx_div_nx = '0;
                end
            end
            RX_START: begin
                if (rx_div == HALF_LAST) begin
                    rx_div_nx = '0;
                    rx_bit_nx = '0;
                    rx_st_nx  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_div_nx = rx_div + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_div == DIV_LAST) begin
                    rx_div_nx = '0;
                    rx_sh_nx  = {rx_s, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_st_nx = RX_STOP;
                    else                rx_bit_nx = rx_bit + 3'd1;
                end else begin
                    rx_div_nx = rx_div + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_div == DIV_LAST) begin
                    rx_st_nx = RX_IDLE;
                    rx_push  = rx_s;
                end else begin
                    rx_div_nx = rx_div + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- receive storage ----------------
    assign do_pop  = pop_req && rx_flag;
    assign do_push = rx_push && (!full || do_pop);

`ifdef TT_RX_FIFO_EN
    localparam int unsigned PW = $clog2(RX_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(RX_DEPTH);
    logic [7:0] mem [RX_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;

    assign full    = (count == FULL_CNT);
    assign rx_flag = (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end
`else
    logic [7:0] hold;
    logic hold_v;

    assign full    = hold_v;
    assign rx_flag = hold_v;
    assign head    = hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold   <= '0;
            hold_v <= 1'b0;
        end else if (do_push) begin
            hold   <= rx_sh;
            hold_v <= 1'b1;
        end else if (do_pop) begin
            hold_v <= 1'b0;
        end
    end
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st   <= TX_IDLE;
            tx_sh   <= '1;
            tx_bit  <= '0;
            tx_div  <= '0;
            txd     <= LINE_IDLE;
            tx_flag <= TX_FLAG_RST;
            rx_st   <= RX_IDLE;
            rx_m    <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
            rx_p    <= LINE_IDLE;
            rx_sh   <= '0;
            rx_bit  <= '0;
            rx_div  <= '0;
            ie      <= IE_RST;
            ovr     <= OVR_RST;
        end else begin
            tx_st   <= tx_st_nx;
            tx_sh   <= tx_sh_nx;
            tx_bit  <= tx_bit_nx;
            tx_div  <= tx_div_nx;
            txd     <= txd_nx;
            tx_flag <= tx_flag_nx;
            rx_st   <= rx_st_nx;
            rx_m    <= rxd;
            rx_s    <= rx_m;
            rx_p    <= rx_s;
            rx_sh   <= rx_sh_nx;
            rx_bit  <= rx_bit_nx;
            rx_div  <= rx_div_nx;
            if (kbd_cmt && op == OP_KIE) ie <= ac_ie;
            if (kbd_cmt && op == OP_KCC) ovr <= 1'b0;
            if (rx_push && full && !do_pop) ovr <= 1'b1;
        end
    end

    assign irq = ie && (rx_flag || tx_flag);

    always_comb begin
        skip       = 1'b0;
        data_avail = 1'b0;
        data_out   = '0;
        if (rd_phase && kbd_sel) begin
            case (op)
                OP_KSF: skip = rx_flag;
                OP_KRS, OP_KRB: begin
                    data_avail = 1'b1;
                    data_out   = {ovr, 3'b000, head};
                end
                OP_KCC: data_avail = 1'b1;
                default: ;
            endcase
        end else if (rd_phase && prt_sel) begin
            case (op)
                OP_TSF: skip = tx_flag;
                OP_SPI: skip = irq;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pdp8_ttx.sv
// Multi-channel KL8E-style console controller: IOT decode and bus merge over NCHAN channels.
// Optional receive FIFO per channel: define TT_RX_FIFO_EN.
module pdp8_ttx
    import pdp8_ttx_pkg::*;
#(
    parameter int unsigned NCHAN    = 1,
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iot,
    input  logic [3:0]       state,
    input  logic [11:0]      mb,
    input  logic [5:0]       io_select,
    input  logic [11:0]      io_data_in,
    output logic [11:0]      io_data_out,
    output logic             io_selected,
    output logic             io_data_avail,
    output logic             io_interrupt,
    output logic             io_skip,
    input  logic [NCHAN-1:0] rxd,
    output logic [NCHAN-1:0] txd
);

    logic done, commit, rd_phase;
    logic [NCHAN-1:0] kbd_hit, prt_hit, ch_skip, ch_avail, ch_irq;
    logic [11:0] ch_data [NCHAN];
    logic unused_bits;

    assign unused_bits = &{1'b0, mb[11:3], io_data_in[10:8]};

    assign rd_phase = iot && (state == ST_DECODE || state == ST_EXEC);
    assign commit   = iot && (state == ST_COMMIT) && !done;

    // done holds off repeat commits for the rest of this IOT
    always_ff @(posedge clk) begin
        if (reset || !iot) done <= 1'b0;
        else if (commit)   done <= 1'b1;
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        localparam dev_codes_t CODES = chan_codes(k);

        assign kbd_hit[k] = iot && (io_select == CODES.kbd);
        assign prt_hit[k] = iot && (io_select == CODES.prt);

        pdp8_ttx_chan #(
            .CLK_DIV (CLK_DIV),
            .RX_DEPTH(RX_DEPTH)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .kbd_sel   (kbd_hit[k]),
            .prt_sel   (prt_hit[k]),
            .rd_phase  (rd_phase),
            .commit    (commit),
            .op        (mb[2:0]),
            .ac_ie     (io_data_in[11]),
            .ac_byte   (io_data_in[7:0]),
            .rxd       (rxd[k]),
            .txd       (txd[k]),
            .skip      (ch_skip[k]),
            .data_avail(ch_avail[k]),
            .data_out  (ch_data[k]),
            .irq       (ch_irq[k])
        );
    end

    always_comb begin
        io_data_out = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            io_data_out = io_data_out | ch_data[k];
        end
    end

    assign io_selected   = |(kbd_hit | prt_hit);
    assign io_skip       = |ch_skip;
    assign io_data_avail = |ch_avail;
    assign io_interrupt  = (|ch_irq) && !reset;

endmodule

// File: tb/tb_pdp8_ttx.sv
// Directed self-checking bench for pdp8_ttx (two channels, CLK_DIV=16).
module tb_pdp8_ttx;

    localparam int NCH  = 2;
    localparam int CDIV = 16;
    localparam int RDEP = 4;
`ifdef TT_RX_FIFO_EN
    localparam int EFF_DEPTH = RDEP;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iot = 1'b0;
    logic [3:0] state = 4'h0;
    logic [11:0] mb = '0;
    logic [5:0] io_select = '0;
    logic [11:0] io_data_in = '0;
    logic [11:0] io_data_out;
    logic io_selected, io_data_avail, io_interrupt, io_skip;
    logic [NCH-1:0] rxd = '1;
    logic [NCH-1:0] txd;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pdp8_ttx #(.NCHAN(NCH), .CLK_DIV(CDIV), .RX_DEPTH(RDEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .iot          (iot),
        .state        (state),
        .mb           (mb),
        .io_select    (io_select),
        .io_data_in   (io_data_in),
        .io_data_out  (io_data_out),
        .io_selected  (io_selected),
        .io_data_avail(io_data_avail),
        .io_interrupt (io_interrupt),
        .io_skip      (io_skip),
        .rxd          (rxd),
        .txd          (txd)
    );

    typedef struct {
        logic [11:0] instr;
        logic [11:0] ac;
        logic        skip;
        logic        sel;
        logic        avail;
        logic [11:0] data;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %o expected %o", nm, act, exp);
    endtask

    // full IOT: decode sample, then one commit cycle; returns at the negedge after the commit edge
    task automatic iot_exec(input logic [11:0] instr, input logic [11:0] ac,
                            output logic sk, output logic sel, output logic av,
                            output logic [11:0] d);
        @(negedge clk);
        iot = 1'b1; mb = instr; io_select = instr[8:3]; io_data_in = ac; state = 4'h1;
        #1;
        sk = io_skip; sel = io_selected; av = io_data_avail; d = io_data_out;
        @(negedge clk);
        state = 4'h3;
        @(negedge clk);
        iot = 1'b0; state = 4'h0;
    endtask

    task automatic iot_do(input logic [11:0] instr, input logic [11:0] ac);
        logic s, e, a;
        logic [11:0] d;
        iot_exec(instr, ac, s, e, a, d);
    endtask

    // decode-phase look at skip without committing
    task automatic peek(input logic [11:0] instr, output logic sk);
        iot = 1'b1; mb = instr; io_select = instr[8:3]; state = 4'h1;
        #1;
        sk = io_skip;
        iot = 1'b0; state = 4'h0;
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rxd[ch] = fr[i];
            repeat (CDIV) @(negedge clk);
        end
    endtask

    // called at the negedge just after the commit edge; returns 152 cycles later
    task automatic check_frame(input int ch, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        repeat (CDIV / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("txd%0d_bit%0d", ch, i), {11'b0, txd[ch]}, {11'b0, fr[i]});
            chk($sformatf("txd%0d_other_idle_bit%0d", ch, i), {11'b0, txd[1 - ch]}, 12'd1);
            if (i < 9) repeat (CDIV) @(negedge clk);
        end
    endtask

    initial begin
        logic s, e, a, got;
        logic [11:0] d;
        logic [7:0] fifo_bytes [5];

        fifo_bytes[0] = 8'hA5; fifo_bytes[1] = 8'h3C; fifo_bytes[2] = 8'h01;
        fifo_bytes[3] = 8'hFF; fifo_bytes[4] = 8'h7E;

        //          instr     ac       skip  sel   avail data
        vecs[0]  = '{12'o6031, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0000};
        vecs[1]  = '{12'o6041, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0000};
        vecs[2]  = '{12'o6045, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0000};
        vecs[3]  = '{12'o6034, 12'o0, 1'b0, 1'b1, 1'b1, 12'o0101};
        vecs[4]  = '{12'o6031, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0000};
        vecs[5]  = '{12'o6036, 12'o0, 1'b0, 1'b1, 1'b1, 12'o0101};
        vecs[6]  = '{12'o6031, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0000};
        vecs[7]  = '{12'o6042, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0000};
        vecs[8]  = '{12'o6041, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0000};
        vecs[9]  = '{12'o6045, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0000};
        vecs[10] = '{12'o6040, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0000};
        vecs[11] = '{12'o6041, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0000};
        vecs[12] = '{12'o6401, 12'o0, 1'b0, 1'b1, 1'b0, 12'o0000};
        vecs[13] = '{12'o6411, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0000};
        vecs[14] = '{12'o6032, 12'o0, 1'b0, 1'b1, 1'b1, 12'o0000};
        vecs[15] = '{12'o6000, 12'o0, 1'b0, 1'b0, 1'b0, 12'o0000};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", {11'b0, io_interrupt}, 12'd0);
        chk("rst_txd", {10'b0, txd}, 12'd3);
        chk("rst_data", io_data_out, 12'o0);
        chk("rst_sel_avail_skip", {9'b0, io_selected, io_data_avail, io_skip}, 12'd0);
        reset = 1'b0;
        @(negedge clk);
        peek(12'o6041, s); chk("post_rst_tsf", {11'b0, s}, 12'd1);
        peek(12'o6031, s); chk("post_rst_ksf", {11'b0, s}, 12'd0);
        chk("post_rst_txd", {10'b0, txd}, 12'd3);
        chk("post_rst_irq", {11'b0, io_interrupt}, 12'd1);

        // TLS on channel 0 and frame timing
        iot_do(12'o6046, 12'o0207);
        peek(12'o6041, s); chk("tls_flag_clear", {11'b0, s}, 12'd0);
        check_frame(0, 8'h87);
        repeat (6) @(negedge clk);
        peek(12'o6041, s); chk("tx_flag_not_early", {11'b0, s}, 12'd0);
        repeat (3) @(negedge clk);
        peek(12'o6041, s); chk("tx_flag_after_frame", {11'b0, s}, 12'd1);

        // one-cycle glitch must be rejected
        @(negedge clk); rxd[0] = 1'b0;
        @(negedge clk); rxd[0] = 1'b1;
        repeat (200) @(negedge clk);
        peek(12'o6031, s); chk("glitch_rejected", {11'b0, s}, 12'd0);

        // receive 0x41 then run the IOT table
        send_byte(0, 8'h41);
        for (int i = 0; i < 16; i++) begin
            iot_exec(vecs[i].instr, vecs[i].ac, s, e, a, d);
            chk($sformatf("vec%0d_skip", i), {11'b0, s}, {11'b0, vecs[i].skip});
            chk($sformatf("vec%0d_sel", i), {11'b0, e}, {11'b0, vecs[i].sel});
            chk($sformatf("vec%0d_avail", i), {11'b0, a}, {11'b0, vecs[i].avail});
            chk($sformatf("vec%0d_data", i), d, vecs[i].data);
        end

        // fill receive store past capacity
        for (int i = 0; i <= EFF_DEPTH; i++) send_byte(0, fifo_bytes[i]);
        iot_exec(12'o6034, 12'o0, s, e, a, d);
        chk("ovr_krs", d, 12'o4000 | {4'b0, fifo_bytes[0]});
        for (int i = 0; i < EFF_DEPTH; i++) begin
            iot_exec(12'o6036, 12'o0, s, e, a, d);
            chk($sformatf("fifo_krb%0d", i), d, 12'o4000 | {4'b0, fifo_bytes[i]});
        end
        peek(12'o6031, s); chk("fifo_empty", {11'b0, s}, 12'd0);
        iot_do(12'o6032, 12'o0);
        iot_exec(12'o6034, 12'o0, s, e, a, d);
        chk("kcc_clears_ovr", d & 12'o4000, 12'o0000);

        // channel 1 printer is independent
        iot_do(12'o6416, 12'o0215);
        peek(12'o6411, s); chk("ch1_tls_flag_clear", {11'b0, s}, 12'd0);
        peek(12'o6041, s); chk("ch0_flag_unaffected", {11'b0, s}, 12'd1);
        check_frame(1, 8'h8D);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            peek(12'o6411, s);
            got = s;
        end
        chk("ch1_tx_done", {11'b0, got}, 12'd1);

        // interrupt enable
        iot_do(12'o6035, 12'o0000);
        iot_do(12'o6405, 12'o0000);
        @(negedge clk);
        chk("kie_off_irq", {11'b0, io_interrupt}, 12'd0);
        peek(12'o6045, s); chk("spi_no_skip", {11'b0, s}, 12'd0);
        iot_do(12'o6035, 12'o4000);
        @(negedge clk);
        chk("kie_on_irq", {11'b0, io_interrupt}, 12'd1);
        peek(12'o6045, s); chk("spi_skip", {11'b0, s}, 12'd1);

        // reset in the middle of a frame
        iot_do(12'o6046, 12'o0000);
        repeat (20) @(negedge clk);
        chk("midframe_txd_low", {11'b0, txd[0]}, 12'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_txd_idle", {10'b0, txd}, 12'd3);
        chk("reset_irq_low", {11'b0, io_interrupt}, 12'd0);
        reset = 1'b0;
        @(negedge clk);
        peek(12'o6041, s); chk("reset_tx_flag", {11'b0, s}, 12'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
